misao_mem_arbiter: RTL and testbench

MISAO_MEM_ARBITER -- requirements
Module: misao_mem_arbiter

---
 rtl/misao_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_misao_mem_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/misao_mem_arbiter.sv
// Core/DMA single-port memory arbiter.
// The core owns the memory by default. A DMA requester gets bursts of up to
// BURST_MAX beats, either when the core is idle or after it has been refused
// for STARVE_MAX cycles. A one-cycle COOL state after every burst guarantees
// the core at least one access between bursts.
module misao_mem_arbiter #(
  parameter int BURST_MAX  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  // core side
  input  logic        core_en_read,
  input  logic        core_en_write,
  input  logic [14:0] core_addr,
  input  logic [7:0]  core_data_out,
  output logic [7:0]  core_data_in,
  output logic        core_stall,
  // DMA side
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [14:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic [7:0]  dma_rdata,
  output logic        dma_rvalid,
  // memory side
  output logic        mem_enable_read,
  output logic        mem_enable_write,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_data_out,
  input  logic [7:0]  mem_data_in
);

  typedef enum logic [1:0] {
    ST_CORE = 2'd0,
    ST_DMA  = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  // Terminal counts; counters stop here and never wrap.
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);
  localparam logic [3:0] BURST_LAST  = 4'(BURST_MAX - 1);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic [3:0] beat_cnt, beat_nxt;
  logic       core_any;
  logic       rd_beat;

  assign core_any = core_en_read | core_en_write;
  assign rd_beat  = dma_gnt & ~dma_we;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CORE;
      starve_cnt <= 4'd0;
      beat_cnt   <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

  // Next-state, counter updates and memory-port steering.
  always_comb begin
    state_nxt        = state;
    starve_nxt       = starve_cnt;
    beat_nxt         = beat_cnt;
    // Core owns the port by default; a double enable forwards only the write.
    mem_enable_read  = core_en_read & ~core_en_write;
    mem_enable_write = core_en_write;
    mem_addr         = core_addr;
    mem_data_out     = core_data_out;
    core_data_in     = mem_data_in;
    core_stall       = 1'b0;
    dma_gnt          = 1'b0;

    case (state)
      ST_CORE: begin
        if (!dma_req) begin
          starve_nxt = 4'd0;
        end else if (!core_any || starve_cnt == STARVE_LAST) begin
          // Core idle, or core has had its quota: this cycle's core access
          // (if any) completes and the DMA takes over next cycle.
          state_nxt  = ST_DMA;
          starve_nxt = 4'd0;
        end else if (starve_cnt < STARVE_LAST) begin
          starve_nxt = starve_cnt + 4'd1;
        end
      end
      ST_DMA: begin
        core_stall       = 1'b1;
        core_data_in     = 8'h00;
        mem_addr         = dma_addr;
        mem_data_out     = dma_wdata;
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        if (dma_req) begin
          dma_gnt          = 1'b1;
          mem_enable_write = dma_we;
          mem_enable_read  = ~dma_we;
          if (beat_cnt == BURST_LAST) begin
            state_nxt = ST_COOL;
            beat_nxt  = 4'd0;
          end else if (beat_cnt < BURST_LAST) begin
            beat_nxt = beat_cnt + 4'd1;
          end
        end else begin
          state_nxt = ST_COOL;
          beat_nxt  = 4'd0;
        end
      end
      ST_COOL: begin
        state_nxt = ST_CORE;
      end
      default: begin
        state_nxt = ST_CORE;
      end
    endcase

    // Reset silences the memory port and both requester handshakes.
    if (rst) begin
      mem_enable_read  = 1'b0;
      mem_enable_write = 1'b0;
      dma_gnt          = 1'b0;
      core_stall       = 1'b0;
      core_data_in     = 8'h00;
    end
  end

  // Capture DMA read data one cycle after each granted read beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= 8'h00;
    end else begin
      dma_rvalid <= rd_beat;
      if (rd_beat) begin
        dma_rdata <= mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_misao_mem_arbiter.sv
// Directed bench for misao_mem_arbiter with a behavioural memory and a
// scoreboard queue for DMA read data.
module tb_misao_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        core_en_read, core_en_write;
  logic [14:0] core_addr;
  logic [7:0]  core_data_out, core_data_in;
  logic        core_stall;
  logic        dma_req, dma_we;
  logic [14:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        dma_gnt, dma_rvalid;
  logic        mem_enable_read, mem_enable_write;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data_out, mem_data_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory: unwritten locations read back their low address byte.
  logic [7:0] mem      [0:32767];
  bit         mem_wr   [0:32767];
  logic [7:0] ref_mem  [0:32767];
  logic [7:0] exp_q    [$];

  misao_mem_arbiter #(.BURST_MAX(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .core_en_read(core_en_read), .core_en_write(core_en_write),
    .core_addr(core_addr), .core_data_out(core_data_out),
    .core_data_in(core_data_in), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_in = mem_wr[mem_addr] ? mem[mem_addr] : mem_addr[7:0];

  always @(posedge clk) begin
    if (mem_enable_write) begin
      mem[mem_addr]    <= mem_data_out;
      mem_wr[mem_addr] <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // check the registered read-return after the rising edge.
  task automatic step(input logic r, input logic crd, input logic cwr,
                      input logic [14:0] caddr, input logic [7:0] cdat,
                      input logic req, input logic we,
                      input logic [14:0] daddr, input logic [7:0] wd,
                      input logic e_gnt, input logic e_stall,
                      input logic e_mrd, input logic e_mwr);
    logic exp_rv;
    logic [7:0] exp_rd;
    @(negedge clk);
    rst = r; core_en_read = crd; core_en_write = cwr; core_addr = caddr;
    core_data_out = cdat; dma_req = req; dma_we = we; dma_addr = daddr;
    dma_wdata = wd;
    #1;
    chk("dma_gnt", dma_gnt, e_gnt);
    chk("core_stall", core_stall, e_stall);
    chk("mem_en_rd", mem_enable_read, e_mrd);
    chk("mem_en_wr", mem_enable_write, e_mwr);
    chk("mem_en_excl", mem_enable_read & mem_enable_write, 1'b0);
    if (r || (e_stall && e_gnt)) chk("core_data_in_zero", core_data_in, 8'h00);
    else if (!e_stall) chk("core_data_in", core_data_in, ref_mem[caddr]);
    if (e_gnt) chk("mem_addr_dma", mem_addr, daddr);
    else if (!e_stall && (e_mrd || e_mwr)) chk("mem_addr_core", mem_addr, caddr);
    if (e_mwr) chk("mem_data_out", mem_data_out, e_stall ? wd : cdat);
    exp_rv = e_gnt & ~we;
    if (exp_rv) exp_q.push_back(ref_mem[daddr]);
    if (e_mwr) begin
      if (e_stall) ref_mem[daddr] = wd;
      else ref_mem[caddr] = cdat;
    end
    @(posedge clk);
    #1;
    chk("dma_rvalid", dma_rvalid, exp_rv);
    if (exp_rv && exp_q.size() > 0) begin
      exp_rd = exp_q.pop_front();
      chk("dma_rdata", dma_rdata, exp_rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = 8'(i);
    rst = 1'b1; core_en_read = 1'b0; core_en_write = 1'b0; core_addr = '0;
    core_data_out = '0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0;
    dma_wdata = '0;

    // Reset: handshakes and memory enables forced low even with requests.
    step(1, 1, 0, 15'h05, 8'h00, 1, 0, 15'h10, 8'h00, 0, 0, 0, 0);
    step(1, 0, 1, 15'h06, 8'hEE, 1, 0, 15'h10, 8'h00, 0, 0, 0, 0);
    chk("rst_rdata", dma_rdata, 8'h00);

    // Idle core, 6 DMA reads 0x10..0x15: burst of 4, COOL, then 2 more.
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h10, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'(16 + i), 8'h00, 1, 1, 1, 0);
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h14, 8'h00, 0, 0, 0, 0);  // COOL
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h14, 8'h00, 0, 0, 0, 0);  // CORE
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h14, 8'h00, 1, 1, 1, 0);
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h15, 8'h00, 1, 1, 1, 0);
    step(0, 0, 0, 15'h00, 8'h00, 0, 0, 15'h00, 8'h00, 0, 1, 0, 0);  // DMA, no req
    step(0, 0, 0, 15'h00, 8'h00, 0, 0, 15'h00, 8'h00, 0, 0, 0, 0);  // COOL
    step(0, 0, 0, 15'h00, 8'h00, 0, 0, 15'h00, 8'h00, 0, 0, 0, 0);  // CORE

    // Starvation: core reads every cycle, DMA held.
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 15'(64 + i), 8'h00, 1, 0, 15'h50, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 15'h48, 8'h00, 1, 0, 15'(80 + i), 8'h00, 1, 1, 1, 0);
    step(0, 1, 0, 15'h49, 8'h00, 1, 0, 15'h54, 8'h00, 0, 0, 1, 0);  // COOL
    step(0, 1, 0, 15'h4A, 8'h00, 1, 0, 15'h54, 8'h00, 0, 0, 1, 0);  // CORE, core wins
    step(0, 0, 0, 15'h00, 8'h00, 0, 0, 15'h00, 8'h00, 0, 0, 0, 0);

    // DMA request dropped after 2 beats.
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h60, 8'h00, 0, 0, 0, 0);
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h60, 8'h00, 1, 1, 1, 0);
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h61, 8'h00, 1, 1, 1, 0);
    step(0, 0, 0, 15'h00, 8'h00, 0, 0, 15'h00, 8'h00, 0, 1, 0, 0);
    step(0, 0, 0, 15'h00, 8'h00, 0, 0, 15'h00, 8'h00, 0, 0, 0, 0);  // COOL
    step(0, 0, 0, 15'h00, 8'h00, 0, 0, 15'h00, 8'h00, 0, 0, 0, 0);  // CORE

    // DMA write 0x5A to 0x20, then core reads it back.
    step(0, 0, 0, 15'h00, 8'h00, 1, 1, 15'h20, 8'h5A, 0, 0, 0, 0);
    step(0, 0, 0, 15'h00, 8'h00, 1, 1, 15'h20, 8'h5A, 1, 1, 0, 1);
    step(0, 0, 0, 15'h00, 8'h00, 0, 0, 15'h00, 8'h00, 0, 1, 0, 0);
    step(0, 1, 0, 15'h20, 8'h00, 0, 0, 15'h00, 8'h00, 0, 0, 1, 0);  // COOL
    chk("dma_wr_mem", mem[15'h20], 8'h5A);

    // Reset during the 2nd beat of a burst.
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h70, 8'h00, 0, 0, 0, 0);
    step(0, 0, 0, 15'h00, 8'h00, 1, 0, 15'h70, 8'h00, 1, 1, 1, 0);
    step(1, 1, 0, 15'h71, 8'h00, 1, 0, 15'h71, 8'h00, 0, 0, 0, 0);
    step(0, 1, 0, 15'h72, 8'h00, 1, 0, 15'h71, 8'h00, 0, 0, 1, 0);
    step(0, 1, 0, 15'h73, 8'h00, 1, 0, 15'h71, 8'h00, 0, 0, 1, 0);
    step(0, 0, 0, 15'h00, 8'h00, 0, 0, 15'h00, 8'h00, 0, 0, 0, 0);

    // Both core enables: only the write is forwarded.
    step(0, 1, 1, 15'h30, 8'h77, 0, 0, 15'h00, 8'h00, 0, 0, 0, 1);
    step(0, 1, 0, 15'h30, 8'h00, 0, 0, 15'h00, 8'h00, 0, 0, 1, 0);
    chk("core_wr_mem", mem[15'h30], 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
